// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter family: default width and
// generic binary<->Gray conversion helpers sized to the widest supported count.
package gray_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 3;
  localparam int GRAY_MAX_W         = 32;

  // Operands narrower than GRAY_MAX_W are zero-extended, which leaves the result exact.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Purely combinational binary to Gray converter.
module gray_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_counter_n.sv
// Up/down Gray-code counter with load, optional saturation, sticky overflow
// and a one-cycle wrap pulse; binary count held internally.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH    = GRAY_WIDTH_DEFAULT,
  parameter int SATURATE = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             Clear,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             wrap_q, wrap_d;
  logic             boundary_s;

  // Boundary step: an enabled, non-load move off either end of the range.
  assign boundary_s = En && !Load && (Up ? (cnt_q == CNT_MAX) : (cnt_q == CNT_MIN));

  // Next-state selection: load beats count; saturation only suppresses the boundary step.
  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    wrap_d = 1'b0;
    if (Load) begin
      cnt_d = LoadVal;
    end else if (En) begin
      if (boundary_s && (SATURATE != 0)) begin
        cnt_d = cnt_q;
      end else if (Up) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
    // Set dominates clear on the overflow flag.
    if (boundary_s) begin
      ovf_d  = 1'b1;
      wrap_d = 1'b1;
    end else if (Clear) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q  <= CNT_MIN;
      ovf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      wrap_q <= wrap_d;
    end
  end

  gray_enc #(.WIDTH(WIDTH)) u_gray_enc (
    .bin_i  (cnt_q),
    .gray_o (Output)
  );

  assign Binary   = cnt_q;
  assign Overflow = ovf_q;
  assign Wrap     = wrap_q;

endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised Gray-code counter, successor to the fixed 3-bit up-only Gray counter. It keeps a WIDTH-bit binary count internally and presents it both as Gray code and as binary. It adds direction control, synchronous load, an optional saturate mode, a sticky overflow flag with explicit clear, and a one-cycle wrap pulse. It sits in the counter/sequence-generator group and drives Gray-coded pointers and state indices for downstream logic.

## Interface
- WIDTH, 3: count width in bits, ≥ 2
- SATURATE, 0: 0 = wrap at the boundaries; 1 = hold at the boundary value
- Clk  in  1  rising-edge clock
- Reset_n  in  1  synchronous reset, active-low; the only clock is Clk
- En  in  1  count enable
- Up  in  1  direction: 1 = increment, 0 = decrement
- Load  in  1  synchronous load strobe
- LoadVal  in  WIDTH  binary value to load
- Clear  in  1  clears Overflow
- Output  out  WIDTH  Gray code of the count
- Binary  out  WIDTH  binary count
- Overflow  out  1  sticky boundary-crossing flag
- Wrap  out  1  one-cycle pulse after a boundary event

## Operation
- State registers:
  - cnt[WIDTH-1:0], binary
  - ovf
  - wrap_q
- Output mapping:
  - Output = cnt ^ (cnt >> 1), combinational from cnt
  - Binary = cnt
  - Overflow = ovf
  - Wrap = wrap_q
- Boundary event: En=1 and Load=0 and either Up=1 with cnt = 2^WIDTH−1, or Up=0 with cnt = 0.
- Priority at each rising edge of Clk, highest first:
  - Reset_n=0: cnt, ovf and wrap_q all go to 0. Every other input is ignored.
  - Load=1: cnt ← LoadVal, wrap_q ← 0. ovf is unchanged unless Clear=1. En and Up are ignored.
  - En=1: cnt moves by ±1 modulo 2^WIDTH.
    - When SATURATE=1 and a boundary event occurs, cnt holds instead.
    - A boundary event sets ovf ← 1 and wrap_q ← 1, in both modes.
  - En=0: cnt holds and wrap_q ← 0.
- Clear=1 clears ovf unless a boundary event occurs in the same cycle; set dominates clear.
- Clear has no effect on cnt or wrap_q.
- Overflow is sticky. Further boundary events leave it at 1.
- wrap_q is 0 on any cycle without a boundary event, so back-to-back events give consecutive Wrap pulses.
- No state machine beyond the counter; the modes are combinational muxing of the next-state value.

## Timing
- Reset values: Output=0, Binary=0, Overflow=0, Wrap=0.
- The first edge with Reset_n=1 after reset may already count.
- Latency of count, load and clear: 1 cycle. Inputs sampled at edge N are visible on the outputs after edge N.
- Output changes by exactly one bit per En step, including across the wrap (wrap mode only).
- Wrap and Overflow assert after the same edge that performs the boundary step, i.e. in the same cycle the count shows 0 or max.
- A mid-count reset (Reset_n=0 for one edge) returns everything to 0 on that edge.
- Up may change on any cycle. It takes effect on the next enabled step.

## Structure
- Shared package gray_pkg holds:
  - functions bin2gray(logic [WIDTH-1:0]) and gray2bin(...), written generically with a width parameter or localparam-sized
  - localparam defaults for WIDTH
- Natural sub-module: gray_enc, a purely combinational binary→Gray converter parametrised on WIDTH and instantiated for Output. gray2bin lives in the package for verification and consumers only.
- The top module holds the counter, the overflow logic and the wrap logic.

## Test plan
- Reset then count: Reset_n=0 for 2 cycles, then En=1, Up=1 for 9 cycles at WIDTH=3.
  - Output sequence: 000,001,011,010,110,111,101,100,000,001.
  - Wrap=1 only in the cycle showing 000 after 100.
  - Overflow=1 from that cycle on.
- Down-count underflow: Load LoadVal=1, then En=1, Up=0 for 2 cycles.
  - Binary goes 1→0→7 and Output goes 001→000→100.
  - Wrap pulses once and Overflow=1.
- Saturate: SATURATE=1, WIDTH=4, Load 14, then En=1, Up=1 for 3 cycles.
  - Binary goes 15,15,15 and Output stays 1000.
  - Overflow=1, and Wrap=1 on the 2nd and 3rd cycles.
- Load priority: Load=1, LoadVal=5, En=1, Up=1 in the same cycle.
  - Binary=5 and Output=111; no increment and Wrap=0.
- Clear versus set: with Overflow=1 and cnt=7 (WIDTH=3), assert Clear, En, Up together.
  - Overflow stays 1, since set dominates.
  - On the next cycle, Clear alone with En=0 gives Overflow=0.
- Gray property: random En/Up/Load for 10k cycles at WIDTH=8.
  - gray2bin(Output)==Binary on every cycle.
  - Each non-load step changes Output by popcount 1 (0 when holding).
